// File: rtl/hamming74_encoder_tx.sv
// Hamming(7,4) transmit encoder: nibbles in, codewords out through a small FIFO
// and an output register, with optional single-bit error injection on load.
module hamming74_encoder_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_data,
  input  logic                          inject_en,
  input  logic [2:0]                    inject_pos,
  output logic [6:0]                    io_out,
  output logic [6:0]                    io_oeb,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              word_count
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and a held-off word stays stable.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          started;
  logic          push;
  logic          pop;
  logic [6:0]    codeword;
  logic [6:0]    inj_mask;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  assign codeword   = encode(in_data);
  // Full FIFO refuses input even if a pop happens this cycle: no pass-through.
  assign in_ready   = started && (level != DEPTH_L);
  assign push       = in_valid && in_ready;
  assign pop        = (level != '0) && (!out_valid || out_ready);
  assign fifo_level = level;

  always_comb begin
    inj_mask = '0;
    if (inject_en && (inject_pos != 3'd0)) begin
      inj_mask[inject_pos - 3'd1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= codeword;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started    <= 1'b0;
      io_oeb     <= 7'h7F;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      out_valid  <= 1'b0;
      io_out     <= 7'h00;
      word_count <= '0;
    end else begin
      started <= 1'b1;
      io_oeb  <= 7'h00;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (out_valid && out_ready) begin
        word_count <= word_count + 1'b1;
      end
      // io_out keeps its last value when the register empties.
      if (pop) begin
        out_valid <= 1'b1;
        io_out    <= mem[rd_ptr] ^ inj_mask;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// Bench for hamming74_encoder_tx: random and directed nibbles, expected codewords
// queued at acceptance and popped by an independent output monitor.
module tb_hamming74_encoder_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        inject_en;
  logic [2:0]  inject_pos;
  logic [6:0]  io_out;
  logic [6:0]  io_oeb;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic [15:0] word_count;

  logic [6:0]  exp_q[$];
  logic [15:0] wc_model;
  int          n_cmp;
  int          n_err;

  hamming74_encoder_tx #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inject_en(inject_en), .inject_pos(inject_pos),
    .io_out(io_out), .io_oeb(io_oeb),
    .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Reference: place data at non-power-of-two positions, then each parity
  // position p is the XOR of every other position whose index has bit p set.
  function automatic logic [6:0] ref_code(input logic [3:0] d, input logic en,
                                          input logic [2:0] pos);
    int         data_pos[4] = '{3, 5, 6, 7};
    logic [7:1] cw;
    cw = '0;
    for (int i = 0; i < 4; i++) cw[data_pos[i]] = d[i];
    for (int p = 1; p <= 4; p = p * 2)
      for (int k = 1; k <= 7; k++)
        if (k != p && (k & p) != 0) cw[p] = cw[p] ^ cw[k];
    if (en && pos != 0) cw[int'(pos)] = ~cw[int'(pos)];
    return cw;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [3:0] d);
    int budget = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: in_ready stuck at 0 expected 1 at %0t", $time);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(ref_code(d, inject_en, inject_pos));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d words outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_word_count", 32'(word_count), 32'(wc_model));
    check("drain_fifo_level", 32'(fifo_level), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  initial begin
    wc_model = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        wc_model = '0;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_word: got %0h expected no word at %0t", io_out, $time);
        end else begin
          check("io_out", 32'(io_out), 32'(exp_q.pop_front()));
        end
        wc_model = wc_model + 16'd1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rand_on;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    inject_en = 1'b0;
    inject_pos = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_io_out", 32'(io_out), 32'h00);
    check("rst_io_oeb", 32'(io_oeb), 32'h7F);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("oeb_after_release", 32'(io_oeb), 32'h00);
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    // Single word and latency.
    out_ready = 1'b1;
    push(4'b1011);
    check("lat_fifo_level", 32'(fifo_level), 32'd1);
    check("lat_out_valid_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_io_out", 32'(io_out), 32'b1010101);
    drain();
    check("wc_one", 32'(word_count), 32'd1);

    // Back-to-back words.
    push(4'h0);
    push(4'hF);
    push(4'b0001);
    drain();
    check("wc_four", 32'(word_count), 32'd4);

    // Backpressure: 1 in output register + 4 in FIFO.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) push(4'(i + 3));
      end
    join_none
    repeat (12) @(posedge clk);
    #1;
    check("bp_fifo_level", 32'(fifo_level), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_io_out_held", 32'(io_out), 32'(ref_code(4'd3, 1'b0, 3'd0)));
    out_ready = 1'b1;
    wait fork;
    drain();
    check("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Error injection.
    inject_en = 1'b1;
    inject_pos = 3'd3;
    push(4'b1011);
    @(posedge clk);
    #1;
    check("inject_pos3", 32'(io_out), 32'b1010001);
    drain();
    inject_pos = 3'd0;
    push(4'b1011);
    @(posedge clk);
    #1;
    check("inject_pos0", 32'(io_out), 32'b1010101);
    drain();
    for (int i = 0; i < 20; i++) begin
      inject_en = 1'($urandom_range(0, 1));
      inject_pos = 3'($urandom_range(0, 7));
      push(4'($urandom_range(0, 15)));
      drain();
    end
    inject_en = 1'b0;
    inject_pos = 3'd0;

    // Random traffic with random backpressure.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 200; i++) push(4'($urandom_range(0, 15)));
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset mid-stream with words queued.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'($urandom_range(0, 15)));
    repeat (2) @(posedge clk);
    #1;
    check("mid_fifo_level", 32'(fifo_level), 32'd3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_io_out", 32'(io_out), 32'h00);
    check("mid_rst_fifo_level", 32'(fifo_level), 32'd0);
    check("mid_rst_word_count", 32'(word_count), 32'd0);
    check("mid_rst_io_oeb", 32'(io_oeb), 32'h7F);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_word_count", 32'(word_count), 32'd0);

    // Counter wrap.
    for (int i = 0; i < 65535; i++) push(4'($urandom_range(0, 15)));
    drain();
    check("wc_max", 32'(word_count), 32'h0000FFFF);
    push(4'hA);
    drain();
    check("wc_wrap", 32'(word_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
